// File: rtl/seq_det_sched.sv
// Round-robin scheduler that streams one W-bit frame at a time, LSB first, into a shared
// serial 4-ones detector and returns the number of detector pulses with the requester ID.
module seq_det_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDW   = $clog2(N_REQ),
  parameter int CW    = $clog2(W + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ*W-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic               o_det_x,
  input  logic               i_det_y,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [IDW-1:0]     o_rsp_id,
  output logic [CW-1:0]      o_rsp_count,
  output logic               o_busy
);

  localparam int              BW       = $clog2(W);
  localparam logic [BW-1:0]   LAST_BIT = BW'(W - 1);
  localparam logic [IDW-1:0]  LAST_REQ = IDW'(N_REQ - 1);
  localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IDW-1:0]  last_r;
  logic [IDW-1:0]  id_r;
  logic [IDW-1:0]  gidx_s;
  logic            gfound_s;
  logic [W-1:0]    shreg_r;
  logic [BW-1:0]   bitcnt_r;
  logic [CW-1:0]   count_r;
  logic            x_r;
  logic            rsp_valid_r;
  logic            count_en_s;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    return IDW'((int'(base) + off) % N_REQ);
  endfunction

  // Round-robin search starting just after the previous winner
  always_comb begin
    gfound_s = 1'b0;
    gidx_s   = last_r;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!gfound_s && i_req_valid[rr_idx(last_r, i)]) begin
        gfound_s = 1'b1;
        gidx_s   = rr_idx(last_r, i);
      end else begin
        gfound_s = gfound_s;
      end
    end
  end

  // Accept pulse is combinational so it pairs with valid in the same IDLE cycle
  always_comb begin
    o_req_ready = '0;
    if (i_rst_n && gfound_s && (state_r == IDLE)) begin
      o_req_ready[gidx_s] = 1'b1;
    end else begin
      o_req_ready = '0;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = gfound_s ? SHIFT : IDLE;
      SHIFT:   state_nxt_s = (bitcnt_r == LAST_BIT) ? DRAIN : SHIFT;
      DRAIN:   state_nxt_s = RESP;
      RESP:    state_nxt_s = i_rsp_ready ? IDLE : RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // The first SHIFT cycle's y reflects idle zeros; DRAIN catches the final bit's y
  assign count_en_s = i_det_y &&
                      (((state_r == SHIFT) && (bitcnt_r != '0)) || (state_r == DRAIN));

  // Frame datapath, detector drive and response registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_r      <= LAST_REQ;
      id_r        <= '0;
      shreg_r     <= '0;
      bitcnt_r    <= '0;
      count_r     <= '0;
      x_r         <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gfound_s) begin
            shreg_r  <= i_req_data[int'(gidx_s)*W +: W];
            x_r      <= i_req_data[int'(gidx_s)*W];
            last_r   <= gidx_s;
            id_r     <= gidx_s;
            count_r  <= '0;
            bitcnt_r <= '0;
          end
        end
        SHIFT: begin
          shreg_r <= shreg_r >> 1;
          if (bitcnt_r == LAST_BIT) begin
            bitcnt_r <= '0;
            x_r      <= 1'b0;
          end else begin
            bitcnt_r <= bitcnt_r + BW'(1);
            x_r      <= shreg_r[1];
          end
        end
        DRAIN: begin
          x_r         <= 1'b0;
          rsp_valid_r <= 1'b1;
        end
        RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          x_r         <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
      if (count_en_s && (count_r != CNT_MAX)) begin
        count_r <= count_r + CW'(1);
      end
    end
  end

  assign o_det_x     = x_r;
  assign o_rsp_valid = rsp_valid_r;
  assign o_rsp_id    = id_r;
  assign o_rsp_count = count_r;
  assign o_busy      = (state_r != IDLE);

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched: queued requesters, a behavioural 4-ones detector,
// and a monitor that checks grants, latency and results against a frame-level model.
module tb_seq_det_sched;
  localparam int N_REQ = 4;
  localparam int W     = 8;
  localparam int IDW   = $clog2(N_REQ);
  localparam int CW    = $clog2(W + 1);

  logic               clk;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               det_x;
  logic               det_y;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [CW-1:0]      rsp_count;
  logic               busy;

  seq_det_sched #(.N_REQ(N_REQ), .W(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_det_x(det_x), .i_det_y(det_y), .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id), .o_rsp_count(rsp_count), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int id; int cnt; int due; } exp_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cycle    = 0;
  logic [W-1:0] rq [N_REQ][$];
  exp_t       sb[$];
  int         grant_log[$];
  logic [N_REQ-1:0] grant_seen = '0;
  bit         inflight = 1'b0;
  bit         prev_valid = 1'b0;
  int         mlast = N_REQ - 1;
  int         gcycle = -100;
  int         last_id = -1;
  int         last_cnt = -1;
  int         n_rsp = 0;
  bit         rand_rsp = 1'b0;
  bit         rsp_force = 1'b1;
  logic [1:0] det_st;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Non-overlapping runs of four ones, scanned LSB first
  function automatic int ref_count(input logic [W-1:0] f);
    int run = 0;
    int n = 0;
    for (int i = 0; i < W; i++) begin
      if (f[i]) begin
        run++;
        if (run == 4) begin
          n++;
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
    return n;
  endfunction

  function automatic int model_grant();
    for (int i = 1; i <= N_REQ; i++) begin
      if (req_valid[(mlast + i) % N_REQ]) return (mlast + i) % N_REQ;
    end
    return -1;
  endfunction

  // Behavioural detector: y is registered and lags the completing bit by one cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_st <= 2'd0;
      det_y  <= 1'b0;
    end else begin
      det_y  <= det_x && (det_st == 2'd3);
      det_st <= (det_x && det_st != 2'd3) ? det_st + 2'd1 : 2'd0;
    end
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Requesters present their queue heads; a granted head is retired next cycle
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_seen[k] && rq[k].size() > 0) void'(rq[k].pop_front());
      grant_seen[k] = 1'b0;
    end
    for (int k = 0; k < N_REQ; k++) begin
      req_valid[k] = (rq[k].size() > 0);
      req_data[k*W +: W] = (rq[k].size() > 0) ? rq[k][0] : '0;
    end
    rsp_ready = rand_rsp ? ($urandom_range(0, 3) != 0) : rsp_force;
  end

  // Monitor: grants against the round-robin model, responses against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", int'(busy), int'(inflight));
      if (req_ready != '0 || (!inflight && req_valid != '0)) begin
        int eg;
        chk("ready_while_busy", int'(inflight), 0);
        eg = model_grant();
        chk("grant_vector", int'(req_ready), (eg < 0) ? 0 : (1 << eg));
        if (req_ready != '0 && !inflight && eg >= 0) begin
          sb.push_back('{id: eg, cnt: ref_count(rq[eg][0]), due: cycle + W + 2});
          inflight = 1'b1;
          mlast = eg;
          gcycle = cycle;
        end
        for (int k = 0; k < N_REQ; k++) if (req_ready[k]) grant_log.push_back(k);
        grant_seen = grant_seen | req_ready;
      end
      if (sb.size() > 0 && cycle == sb[0].due) chk("rsp_due", int'(rsp_valid), 1);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          chk("rsp_id", int'(rsp_id), sb[0].id);
          chk("rsp_count", int'(rsp_count), sb[0].cnt);
          if (!prev_valid) chk("rsp_latency", cycle, sb[0].due);
          if (rsp_ready) begin
            void'(sb.pop_front());
            inflight = 1'b0;
            last_id = int'(rsp_id);
            last_cnt = int'(rsp_count);
            n_rsp++;
          end
        end
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int max_cyc);
    int t = 0;
    bit pend;
    pend = 1'b1;
    while (pend && t < max_cyc) begin
      step();
      t++;
      pend = inflight || sb.size() > 0 || req_valid != '0;
      for (int k = 0; k < N_REQ; k++) if (rq[k].size() > 0) pend = 1'b1;
    end
    if (pend) chk("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, int'(req_ready), 0);
    chk({tag, "_det_x"}, int'(det_x), 0);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, int'(rsp_id), 0);
    chk({tag, "_rsp_count"}, int'(rsp_count), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic send_one(input int k, input logic [W-1:0] f, input int exp_cnt);
    rq[k].push_back(f);
    wait_idle(200);
    chk("dir_id", last_id, k);
    chk("dir_count", last_cnt, exp_cnt);
  endtask

  initial begin
    int t;
    int n0;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // All requesters valid at once: fair rotation starting from requester 0
    grant_log.delete();
    rq[0].push_back(8'hFF); rq[0].push_back(8'h0F);
    rq[1].push_back(8'hF7); rq[2].push_back(8'hE0); rq[3].push_back(8'h3C);
    wait_idle(500);
    chk("order_len", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("order", grant_log[i], exp_order[i]);

    send_one(0, 8'hFF, 2);
    send_one(1, 8'hF7, 1);

    // Back-to-back frames: the trailing ones of the first must not combine with the second
    n0 = n_rsp;
    rq[0].push_back(8'hE0); rq[0].push_back(8'h01);
    wait_idle(200);
    chk("flush_rsp_count", n_rsp - n0, 2);
    chk("flush_count", last_cnt, 0);

    // Requesters 0 and 2 busy, requester 1 joins later
    for (int i = 0; i < 3; i++) begin
      rq[0].push_back(8'hF0 ^ W'(i)); rq[2].push_back(8'h7F >> i);
    end
    repeat (15) step();
    rq[1].push_back(8'hFF); rq[1].push_back(8'hEF);
    wait_idle(500);

    // Backpressure with another request pending
    rsp_force = 1'b0;
    rq[1].push_back(8'hFF); rq[3].push_back(8'h0F);
    t = 0;
    while (!rsp_valid && t < 100) begin step(); t++; end
    chk("bp_valid_seen", int'(rsp_valid), 1);
    n0 = n_rsp;
    repeat (5) step();
    chk("bp_held", n_rsp, n0);
    rsp_force = 1'b1;
    wait_idle(300);

    // Reset during SHIFT: frame lost, then regranted from requester 0
    gcycle = -100;
    rq[0].push_back(8'hFF); rq[0].push_back(8'hFF);
    t = 0;
    while (gcycle < 0 && t < 100) begin step(); t++; end
    chk("rst_grant_seen", int'(gcycle >= 0), 1);
    t = 0;
    while (cycle != gcycle + 3 && t < 100) begin step(); t++; end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    inflight = 1'b0;
    prev_valid = 1'b0;
    mlast = N_REQ - 1;
    grant_seen = '0;
    rq[0].push_front(8'hFF);
    repeat (2) step();
    rst_n = 1'b1;
    wait_idle(300);
    chk("after_rst_id", last_id, 0);
    chk("after_rst_count", last_cnt, 2);

    // Randomised traffic with random backpressure
    rand_rsp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int k;
      k = int'($urandom_range(0, N_REQ - 1));
      rq[k].push_back(W'($urandom) | W'($urandom));
      repeat ($urandom_range(0, 4)) step();
    end
    wait_idle(20000);
    rand_rsp = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Round-robin scheduler that shares one serial 4-ones sequence detector (2-bit FSM, registered `y`, non-overlapping detection) between `N_REQ` requesters. It accepts one `W`-bit frame at a time and shifts it LSB-first into the detector's `x` input. It counts the detector's `y` pulses for that frame, flushes the detector with a zero bit, and returns the count with the requester ID. The block sits between the requester-side valid/ready ports and the detector instance.

## Interface
- `N_REQ`, 4, number of requesters; 2..16.
- `W`, 8, frame width in bits; at least 4.
- `IDW`, `$clog2(N_REQ)`, requester ID width.
- `CW`, `$clog2(W+1)`, detection count width.

- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: asynchronous, active-low reset; clock `i_clk`.
- `i_req_valid`, in, `N_REQ`: per-requester frame valid.
- `i_req_data`, in, `N_REQ*W`: frames; requester k occupies bits `[k*W +: W]`.
- `o_req_ready`, out, `N_REQ`: one-hot accept pulse.
- `o_det_x`, out, 1: serial bit to the detector `x` input.
- `i_det_y`, in, 1: detector registered output `y`.
- `o_rsp_valid`, out, 1: result valid.
- `i_rsp_ready`, in, 1: result accept.
- `o_rsp_id`, out, `IDW`: requester index of the result.
- `o_rsp_count`, out, `CW`: number of `y` pulses in the frame.
- `o_busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states are IDLE, SHIFT, DRAIN and RESP.
- **IDLE**
  - `o_det_x` is 0.
  - If any `i_req_valid` is high, grant round-robin: search from `last+1` upward, modulo `N_REQ`.
  - On a grant, pulse `o_req_ready[g]` for 1 cycle, latch the frame into the shift register, set `last=g`, clear the count, and go to SHIFT.
  - `last` resets to `N_REQ-1`, so requester 0 has first priority.
- **SHIFT** (exactly `W` cycles)
  - `o_det_x` equals `shreg[0]`; the register shifts right each cycle.
  - A bit counter runs from 0 to `W-1`; after the last bit, go to DRAIN.
- **DRAIN** (1 cycle)
  - `o_det_x` is 0. This captures the `y` produced by the final bit and forces the detector back to state 00.
  - Go to RESP.
- **Counting:** the count increments on `i_det_y` in every SHIFT cycle except the first, and in the DRAIN cycle. A `y` in the first SHIFT cycle reflects IDLE zeros and is ignored (it is 0 by construction). The count saturates at `2^CW-1`, which is unreachable in normal use since the maximum is `W/4`.
- **RESP**
  - `o_rsp_valid` is high; `o_rsp_id` and `o_rsp_count` are held stable.
  - When `i_rsp_ready` is high, go to IDLE. No new grant is issued in this cycle.
- Only one frame is in flight; `o_req_ready` is 0 in all states except IDLE.
- The scheduler never changes `i_req_data` sampling after a grant. Requester data may change after its ready pulse.
- Frame isolation: at least one `x=0` cycle precedes every frame, so detection state never carries across frames.
- Non-granted requesters keep `i_req_valid` asserted; the scheduler does not drop them.

## Timing
- Reset values:
  - state IDLE
  - `o_req_ready = 0`
  - `o_det_x = 0`
  - `o_rsp_valid = 0`
  - `o_rsp_id = 0`
  - `o_rsp_count = 0`
  - `o_busy = 0`
  - `last = N_REQ-1`
  - shift register and counters 0
- Grant in cycle A (IDLE, ready pulse):
  - SHIFT bits 0..`W-1` are driven in cycles A+1..A+W.
  - DRAIN is cycle A+W+1.
  - `o_rsp_valid` rises in cycle A+W+2.
- Minimum frame period is `W+3` cycles (IDLE, W SHIFT, DRAIN, 1-cycle RESP).
- The detector `y` lags the `x` bit it completes by 1 cycle.
- Backpressure: `o_rsp_valid` stays high and the outputs stay stable for any number of cycles with `i_rsp_ready` low.
- Reset mid-frame returns to reset values asynchronously. The frame is lost; no response is produced.
- Simultaneous valids resolve in a single cycle with no bubble. A valid that rises during a busy frame is considered at the next IDLE.

## Test plan
- Req0 sends `8'hFF` → ready pulse at A, `o_rsp_valid` at A+10, id 0, count 2.
- Req1 sends `8'hF7` (LSB-first 1,1,1,0,1,1,1,1) → count 1; the last detection is captured in DRAIN.
- Req0 sends `8'hE0`, then `8'h01` → counts 0 and 0, proving the flush blocks detection across frames.
- Req0 and req2 are valid from reset and re-assert after each grant, with req1 joining later → grants go 0, 2, then 0 before 1 only if req1 is not yet valid; with all valid, order is 0, 1, 2, 3, 0.
- `i_rsp_ready` is held low 5 cycles in RESP → valid, id and count are stable, no new ready pulse, and the grant follows the cycle after acceptance.
- `i_rst_n` is asserted in SHIFT cycle A+3 → all outputs go to reset values immediately. After release, the same request is regranted to req0 and the full count is correct.
